// File: rtl/mcp3208_pkg.sv
// Shared definitions for the MCP3208 chip-side emulator and its SPI master.
// Edge numbers count sclk rising edges from the start bit; fall fk follows rk.
package mcp3208_pkg;

  localparam int unsigned DEF_NCH = 8;
  localparam int unsigned DEF_DW  = 12;

  localparam int unsigned START_EDGE     = 1;
  localparam int unsigned CHAN_LAST_EDGE = 5;
  localparam int unsigned CAPTURE_EDGE   = 6;
  localparam int unsigned MSB_FIRST_EDGE = 7;
  localparam int unsigned LSB_FIRST_EDGE = 19;
  localparam int unsigned TRAIL_EDGE     = 30;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StCmd,
    StSample,
    StMsb,
    StLsb,
    StTrail
  } state_e;

  // Saturating edge counter so long trailing frames never wrap back into the data window.
  function automatic logic [4:0] edge_inc(logic [4:0] n);
    return (n == 5'd31) ? n : n + 5'd1;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-lane synchronizer chain with a one-flop edge detector per lane.
module spi_in_sync #(
  parameter int unsigned LANES  = 3,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] async_in,
  output logic [LANES-1:0] level,
  output logic [LANES-1:0] rise,
  output logic [LANES-1:0] fall
);

  logic [LANES-1:0] chain_q [STAGES];
  logic [LANES-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      chain_q[0] <= async_in;
      for (int i = 1; i < int'(STAGES); i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[STAGES-1];
    end
  end

  assign level = chain_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcp3208_emu.sv
// MCP3208 chip-side SPI responder: decodes start/SGL/channel and returns a 12-bit
// value MSB-first then LSB-first, sampled once per frame from the parallel bus.
module mcp3208_emu
  import mcp3208_pkg::*;
#(
  parameter int unsigned NCH         = DEF_NCH,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              din,
  output logic              dout,
  output logic              dout_oe,
  input  logic [NCH*DW-1:0] ch_data,
  output logic              conv_strobe,
  output logic [2:0]        conv_chan,
  output logic              conv_sgl,
  output logic              frame_err
);

  localparam int unsigned IW = $clog2(DW);

  logic [2:0] lvl, rise, fall;
  logic       cs_lvl, cs_rise, cs_fall, sclk_rise, sclk_fall, din_lvl;
  logic       unused_din_edges;

  spi_in_sync #(
    .LANES (3),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in({din, sclk, cs}),
    .level   (lvl),
    .rise    (rise),
    .fall    (fall)
  );

  assign cs_lvl           = lvl[0];
  assign cs_rise          = rise[0];
  assign cs_fall          = fall[0];
  assign sclk_rise        = rise[1];
  assign sclk_fall        = fall[1];
  assign din_lvl          = lvl[2];
  assign unused_din_edges = rise[2] ^ fall[2];

  state_e          state_q, state_d;
  logic [4:0]      rcnt_q, rcnt_d;
  logic            sgl_q, sgl_d;
  logic [2:0]      chan_q, chan_d;
  logic [DW-1:0]   word_q, word_d;
  logic            dout_q, dout_d, oe_q, oe_d;
  logic            strobe_q, strobe_d, err_q, err_d;
  logic [2:0]      conv_chan_q, conv_chan_d;
  logic            conv_sgl_q, conv_sgl_d;
  logic            armed_q, armed_d;
  logic [IW-1:0]   bit_idx;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise && state_q != StIdle) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:      if (cs_fall && armed_q) state_d = StWaitStart;
        StWaitStart: if (sclk_rise && din_lvl) state_d = StCmd;
        StCmd:       if (sclk_rise && rcnt_q == 5'(CHAN_LAST_EDGE - 1)) state_d = StSample;
        StSample:    if (sclk_fall && rcnt_q == 5'(CAPTURE_EDGE)) state_d = StMsb;
        StMsb:       if (sclk_fall && rcnt_q == 5'(LSB_FIRST_EDGE - 1)) state_d = StLsb;
        StLsb:       if (sclk_fall && rcnt_q == 5'(TRAIL_EDGE - 1)) state_d = StTrail;
        StTrail:     state_d = StTrail;
        default:     state_d = StIdle;
      endcase
    end
  end

  // MSB phase walks B11..B0 down, LSB phase walks B1..B11 up.
  always_comb begin
    if (state_q == StMsb) bit_idx = IW'(5'(MSB_FIRST_EDGE + DW - 1) - rcnt_q);
    else                  bit_idx = IW'(rcnt_q - 5'(LSB_FIRST_EDGE - 1));
  end

  always_comb begin
    rcnt_d      = rcnt_q;
    sgl_d       = sgl_q;
    chan_d      = chan_q;
    word_d      = word_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    conv_chan_d = conv_chan_q;
    conv_sgl_d  = conv_sgl_q;
    strobe_d    = 1'b0;
    err_d       = 1'b0;
    armed_d     = armed_q | cs_lvl;
    if (cs_rise && state_q != StIdle) begin
      oe_d   = 1'b0;
      dout_d = 1'b0;
      err_d  = (state_q == StCmd) || (state_q == StSample) || (state_q == StMsb);
    end else begin
      case (state_q)
        StIdle: begin
          oe_d   = 1'b0;
          dout_d = 1'b0;
          rcnt_d = '0;
        end
        StWaitStart: if (sclk_rise && din_lvl) rcnt_d = 5'(START_EDGE);
        StCmd: begin
          if (sclk_rise) begin
            rcnt_d = edge_inc(rcnt_q);
            if (rcnt_q == 5'(START_EDGE)) sgl_d = din_lvl;
            else                          chan_d = {chan_q[1:0], din_lvl};
          end
        end
        default: begin
          if (sclk_rise) rcnt_d = edge_inc(rcnt_q);
          if (sclk_fall) begin
            case (state_q)
              StSample: begin
                if (rcnt_q == 5'(CAPTURE_EDGE)) begin
                  word_d      = ch_data[chan_q*DW +: DW];
                  strobe_d    = 1'b1;
                  conv_chan_d = chan_q;
                  conv_sgl_d  = sgl_q;
                  oe_d        = 1'b1;
                  dout_d      = 1'b0;
                end
              end
              StMsb, StLsb: dout_d = word_q[bit_idx];
              default:      dout_d = 1'b0;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q      <= '0;
      sgl_q       <= 1'b0;
      chan_q      <= '0;
      word_q      <= '0;
      dout_q      <= 1'b0;
      oe_q        <= 1'b0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
      conv_chan_q <= '0;
      conv_sgl_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      rcnt_q      <= rcnt_d;
      sgl_q       <= sgl_d;
      chan_q      <= chan_d;
      word_q      <= word_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
      conv_chan_q <= conv_chan_d;
      conv_sgl_q  <= conv_sgl_d;
      armed_q     <= armed_d;
    end
  end

  assign dout        = dout_q;
  assign dout_oe     = oe_q;
  assign conv_strobe = strobe_q;
  assign conv_chan   = conv_chan_q;
  assign conv_sgl    = conv_sgl_q;
  assign frame_err   = err_q;

endmodule
